seq_signed_div: RTL
===================

SEQ_SIGNED_DIV -- requirements
Module: seq_signed_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the divisor/quotient/remainder width; the dividend width SHALL be 2*WIDTH.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have port start, input, 1, a request that is sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, 2*WIDTH, the signed two's-complement dividend.
REQ-006 The block SHALL have port divisor, input, WIDTH, the signed two's-complement divisor.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, WIDTH, the signed quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH, the signed remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1, the divisor==0 flag.
REQ-012 The block SHALL have port overflow, output, 1, set when the quotient is not representable in WIDTH signed bits.

Function
REQ-013 The block SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with start=1 the block SHALL register operand signs and unsigned magnitudes, clear both flags, load count=WIDTH and go to CALC.
- Exception: divisor==0 SHALL go to FIX and set div_by_zero.
- Exception: |dividend|[2W-1:W] >= |divisor| SHALL go to FIX and set overflow.
REQ-015 In CALC the block SHALL retire one quotient bit per cycle by restoring division (shift partial remainder left, trial-subtract |divisor|, keep if non-negative), decrement count, and go to FIX after WIDTH cycles.
REQ-016 In FIX the block SHALL negate the quotient magnitude when the operand signs differ and SHALL give the remainder the dividend's sign (truncation toward zero).
- Overflow: a positive quotient > 2^(W-1)-1 or a negative quotient magnitude > 2^(W-1) SHALL set overflow.
REQ-017 If either flag is set, quotient and remainder SHALL be driven to 0.
REQ-018 In DONE the block SHALL update quotient, remainder and the flags, pulse done for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be fixed: done is high on the (WIDTH+2)th edge after the start-sampling edge for normal operation, and on the 2nd edge for div_by_zero or pre-check overflow.
REQ-020 The outputs SHALL hold their last values until the next DONE.
REQ-021 start while busy=1 SHALL be ignored without corrupting the operation in flight.
REQ-022 start asserted in the same cycle that DONE returns to IDLE SHALL NOT be accepted; acceptance occurs on the next IDLE cycle.
REQ-023 Operand inputs SHALL be read only on the accepting edge; later changes SHALL have no effect.
REQ-024 The most-negative dividend and divisor SHALL be handled by unsigned magnitudes at full width with no extra sign bit.

Reset
REQ-025 rst_n=0 SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0 and clear the internal registers, including mid-CALC.
REQ-026 After rst_n rises, the first start SHALL be accepted on the first clk edge.

Structure
REQ-027 The state enum, and the count width $clog2(WIDTH+1), SHALL live in shared package div_pkg.
REQ-028 The trial-subtract/shift iteration SHALL be a combinational sub-module div_step, instantiated once.

Verification (WIDTH=4)
REQ-029 dividend=42, divisor=-6 -> quotient=-7, remainder=0, flags 0, done 6 cycles after start.
REQ-030 dividend=-43, divisor=5 -> quotient=-8, remainder=-3, flags 0.
REQ-031 dividend=43, divisor=5 -> overflow=1, quotient=0, remainder=0.
REQ-032 dividend=-128, divisor=-8 -> overflow=1 via pre-check, done 2 cycles after start.
REQ-033 dividend=7, divisor=0 -> div_by_zero=1, quotient=0, done 2 cycles after start.
REQ-034 Case 1: start 42/-6, then re-assert start with 7/1 during CALC -> result stays -7/0.
- Case 2: pulse rst_n low mid-CALC -> all outputs 0 and busy=0 immediately, and no done pulse occurs.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width: must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift, trial-subtract, keep if non-negative.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_nxt_c,
  output logic [WIDTH-1:0] quo_nxt_c
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem < dmag on entry, so a successful subtraction always fits back in WIDTH bits.
  always_comb begin
    trial     = {rem, quo[WIDTH-1]};
    diff      = trial - {1'b0, dmag};
    rem_nxt_c = trial[WIDTH-1:0];
    quo_nxt_c = {quo[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, dmag}) begin
      rem_nxt_c = diff[WIDTH-1:0];
      quo_nxt_c = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_signed_div.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, truncating toward zero.
module seq_signed_div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic             q_neg_q, r_neg_q, dz_q, ovf_q;
  logic [WIDTH-1:0] dmag_q, rem_q, quo_q;
  logic [CW-1:0]    cnt_q;

  logic [DW-1:0]    dvd_mag;
  logic [WIDTH-1:0] dvs_mag, step_rem, step_quo;
  logic             pre_dz, pre_ovf, fix_ovf;

  // Full-width magnitudes: the most-negative value maps onto its unsigned equivalent.
  always_comb begin
    dvd_mag = dividend[DW-1] ? -dividend : dividend;
    dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
    pre_dz  = (divisor == '0);
    pre_ovf = (dvd_mag[DW-1:WIDTH] >= dvs_mag);
    fix_ovf = q_neg_q ? (quo_q > HALF) : (quo_q >= HALF);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem_q),
    .quo       (quo_q),
    .dmag      (dmag_q),
    .rem_nxt_c (step_rem),
    .quo_nxt_c (step_quo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (pre_dz || pre_ovf) ? FIX : CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      dmag_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          q_neg_q <= dividend[DW-1] ^ divisor[WIDTH-1];
          r_neg_q <= dividend[DW-1];
          dmag_q  <= dvs_mag;
          rem_q   <= dvd_mag[DW-1:WIDTH];
          quo_q   <= dvd_mag[WIDTH-1:0];
          cnt_q   <= CW'(WIDTH);
          dz_q    <= pre_dz;
          ovf_q   <= !pre_dz && pre_ovf;
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          if (dz_q || ovf_q || fix_ovf) begin
            ovf_q <= ovf_q || (!dz_q && fix_ovf);
            quo_q <= '0;
            rem_q <= '0;
          end else begin
            quo_q <= q_neg_q ? -quo_q : quo_q;
            rem_q <= r_neg_q ? -rem_q : rem_q;
          end
        end
        DONE: begin
          quotient    <= quo_q;
          remainder   <= rem_q;
          div_by_zero <= dz_q;
          overflow    <= ovf_q;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
